// File: rtl/mem_pkg.sv
// Shared definitions for the synchronous memory block: access sizes, FSM
// states and the access legality check used on both store and load paths.
package mem_pkg;

  localparam logic [1:0] ACCESS_SIZE_BYTE = 2'b00;
  localparam logic [1:0] ACCESS_SIZE_HALF = 2'b01;
  localparam logic [1:0] ACCESS_SIZE_WORD = 2'b10;
  localparam logic [1:0] ACCESS_SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  // An access faults when its size is reserved, it is not naturally aligned,
  // or its address lies beyond the stored bytes.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [1:0] offset,
                                        input logic       in_range);
    logic misfit;
    case (size)
      ACCESS_SIZE_BYTE: misfit = 1'b0;
      ACCESS_SIZE_HALF: misfit = offset[0];
      ACCESS_SIZE_WORD: misfit = |offset;
      default:          misfit = 1'b1;
    endcase
    return misfit || !in_range;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: turns a right-aligned store into per-lane enables and
// replicated lane data, and turns a read word into an extended load result.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_data,
  output logic [3:0]  st_byte_en,
  output logic [31:0] st_lanes,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_offset,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_en;
      logic [7:0] lane_byte;

      // Per-lane enable and source byte for the store path.
      always_comb begin
        lane_en   = 1'b0;
        lane_byte = st_data[7:0];
        case (st_size)
          ACCESS_SIZE_BYTE: begin
            lane_en   = (st_offset == 2'(gi));
            lane_byte = st_data[7:0];
          end
          ACCESS_SIZE_HALF: begin
            lane_en   = (st_offset[1] == 1'(gi / 2));
            lane_byte = st_data[8*(gi%2) +: 8];
          end
          ACCESS_SIZE_WORD: begin
            lane_en   = 1'b1;
            lane_byte = st_data[8*gi +: 8];
          end
          default: begin
            lane_en   = 1'b0;
            lane_byte = st_data[7:0];
          end
        endcase
      end

      assign st_byte_en[gi]       = lane_en;
      assign st_lanes[8*gi +: 8] = lane_byte;
    end
  endgenerate

  assign ld_shifted = ld_word >> {ld_offset, 3'b000};

  // Load path: bring the addressed lane down to bit 0 and extend it.
  always_comb begin
    ld_data = 32'h0;
    case (ld_size)
      ACCESS_SIZE_BYTE: ld_data = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                              : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      ACCESS_SIZE_HALF: ld_data = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                              : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      ACCESS_SIZE_WORD: ld_data = ld_word;
      default:          ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_sync.sv
// Word-organised memory with valid/ready request and response channels,
// configurable latency, access fault detection and a word preload port.
module mem_sync
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_WIDTH  = 32,
  parameter int LATENCY     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  input  logic                  setup_valid,
  input  logic [ADDR_WIDTH-1:0] setup_addr,
  input  logic [31:0]           setup_data
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  mem_state_e             state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic                   write_reg, unsigned_reg;
  logic [1:0]             size_reg;
  logic [31:0]            wdata_reg;

  logic [31:0]            words [0:DEPTH_WORDS-1];
  logic [31:0]            rd_word_reg;

  // The request being worked on: live inputs while idle, the latched copy after.
  logic                   in_idle;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic                   cur_write, cur_fault, lat_fault;
  logic [1:0]             cur_size;
  logic [31:0]            cur_wdata;
  logic                   accept, enter_resp;
  logic                   setup_we, store_we, mem_we;
  logic [IDX_W-1:0]       wr_idx, rd_idx;
  logic [3:0]             st_byte_en, wr_be;
  logic [31:0]            st_lanes, wr_data, ld_data;

  assign in_idle   = (state_reg == IDLE);
  assign req_ready = reset_n && in_idle && !setup_valid;
  assign accept    = req_valid && req_ready;

  assign cur_addr  = in_idle ? req_addr  : addr_reg;
  assign cur_write = in_idle ? req_write : write_reg;
  assign cur_size  = in_idle ? req_size  : size_reg;
  assign cur_wdata = in_idle ? req_wdata : wdata_reg;

  assign cur_fault = access_fault(cur_size, cur_addr[1:0], {1'b0, cur_addr} < BYTE_LIMIT);
  assign lat_fault = access_fault(size_reg, addr_reg[1:0], {1'b0, addr_reg} < BYTE_LIMIT);

  // Next-state and latency countdown; flags the cycle that enters RESP.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          count_next = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        count_next = count_reg - CNT_W'(1);
        if (count_reg <= CNT_W'(1)) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, countdown and the request latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      size_reg     <= ACCESS_SIZE_BYTE;
      unsigned_reg <= 1'b0;
      wdata_reg    <= 32'h0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (accept) begin
        addr_reg     <= req_addr;
        write_reg    <= req_write;
        size_reg     <= req_size;
        unsigned_reg <= req_unsigned;
        wdata_reg    <= req_wdata;
      end
    end
  end

  mem_lane_fmt u_lane_fmt (
    .st_size     (cur_size),
    .st_offset   (cur_addr[1:0]),
    .st_data     (cur_wdata),
    .st_byte_en  (st_byte_en),
    .st_lanes    (st_lanes),
    .ld_word     (rd_word_reg),
    .ld_offset   (addr_reg[1:0]),
    .ld_size     (size_reg),
    .ld_unsigned (unsigned_reg),
    .ld_data     (ld_data)
  );

  // Setup and store commits never coincide: an accept implies setup_valid is low.
  assign setup_we = reset_n && in_idle && setup_valid && ({1'b0, setup_addr} < BYTE_LIMIT);
  assign store_we = enter_resp && cur_write && !cur_fault;
  assign mem_we   = setup_we || store_we;
  assign wr_idx   = setup_we ? setup_addr[IDX_W+1:2] : cur_addr[IDX_W+1:2];
  assign wr_be    = setup_we ? 4'hF : st_byte_en;
  assign wr_data  = setup_we ? setup_data : st_lanes;
  assign rd_idx   = cur_addr[IDX_W+1:2];

  // Array with byte-enable write and registered read; contents are never reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) words[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_word_reg <= words[rd_idx];
  end

  assign resp_valid = (state_reg == RESP);
  assign resp_fault = resp_valid && lat_fault;
  assign resp_rdata = (resp_valid && !lat_fault && !write_reg) ? ld_data : 32'h0;

endmodule

// File: tb/tb_mem_sync.sv
// Directed bench for mem_sync: unit 0 runs with LATENCY=1, unit 1 with LATENCY=3.
module tb_mem_sync;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, resp_fault, setup_valid;
  logic [31:0] req_addr, req_wdata, setup_addr, setup_data;
  logic        req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] resp_rdata [2];
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  mem_sync #(.DEPTH_WORDS(64), .ADDR_WIDTH(32), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]),
    .setup_valid(setup_valid[0]), .setup_addr(setup_addr), .setup_data(setup_data)
  );

  mem_sync #(.DEPTH_WORDS(64), .ADDR_WIDTH(32), .LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]),
    .setup_valid(setup_valid[1]), .setup_addr(setup_addr), .setup_data(setup_data)
  );

  task automatic do_setup(input int u, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    setup_valid[u] = 1'b1;
    setup_addr     = a;
    setup_data     = d;
    @(negedge clock);
    setup_valid[u] = 1'b0;
  endtask

  // One complete request/response with resp_ready held high.
  task automatic do_access(input int u, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic flt, output int lat);
    int n = 0;
    @(negedge clock);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid[u] = 1'b1; resp_ready[u] = 1'b1;
    #1;
    while (!req_ready[u] && n < 20) begin @(negedge clock); #1; n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL accept_timeout u=%0d: req_ready=%0b want 1", u, req_ready[u]); end
    @(posedge clock);
    @(negedge clock);
    req_valid[u] = 1'b0;
    lat = 1;
    while (!resp_valid[u] && lat < 20) begin @(negedge clock); lat++; end
    checks++;
    if (lat >= 20) begin errors++; $display("FAIL resp_timeout u=%0d: resp_valid=%0b want 1", u, resp_valid[u]); end
    rd  = resp_rdata[u];
    flt = resp_fault[u];
    $display("txn u=%0d wr=%0b sz=%0d uns=%0b addr=%h wdata=%h -> rdata=%h fault=%0b lat=%0d",
             u, wr, sz, uns, a, wd, rd, flt, lat);
    @(posedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    req_valid = '0; resp_ready = '0; setup_valid = '0;
    req_addr = '0; req_wdata = '0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    setup_addr = '0; setup_data = '0;
    #2 reset_n = 1'b0;
    @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      checks++; if (req_ready[u] !== 1'b0) begin errors++; $display("FAIL reset_req_ready u=%0d: got %b want 0", u, req_ready[u]); end
      checks++; if (resp_valid[u] !== 1'b0) begin errors++; $display("FAIL reset_resp_valid u=%0d: got %b want 0", u, resp_valid[u]); end
      checks++; if (resp_rdata[u] !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata u=%0d: got %h want 0", u, resp_rdata[u]); end
      checks++; if (resp_fault[u] !== 1'b0) begin errors++; $display("FAIL reset_resp_fault u=%0d: got %b want 0", u, resp_fault[u]); end
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++; if (req_ready[u] !== 1'b1) begin errors++; $display("FAIL idle_req_ready u=%0d: got %b want 1", u, req_ready[u]); end
    end
  endtask

  task automatic test_load_ext();
    logic [1:0]  t_sz  [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1};
    logic        t_uns [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_a   [7] = '{32'h1, 32'h2, 32'h0, 32'h3, 32'h0, 32'h0, 32'h2};
    logic [31:0] t_exp [7] = '{32'hFFFFFFAA, 32'h00008899, 32'h8899AABB, 32'h00000088,
                               32'hFFFFAABB, 32'hFFFFFFBB, 32'hFFFF8899};
    logic [31:0] rd; logic flt; int lat;
    do_setup(0, 32'h0, 32'h8899AABB);
    for (int i = 0; i < 7; i++) begin
      do_access(0, 1'b0, t_sz[i], t_uns[i], t_a[i], 32'h0, rd, flt, lat);
      checks++; if (rd !== t_exp[i]) begin errors++; $display("FAIL load_data[%0d]: got %h want %h", i, rd, t_exp[i]); end
      checks++; if (flt !== 1'b0) begin errors++; $display("FAIL load_fault[%0d]: got %b want 0", i, flt); end
      checks++; if (lat != 1) begin errors++; $display("FAIL load_latency[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_store();
    logic [31:0] rd; logic flt; int lat;
    do_setup(0, 32'h4, 32'h0);
    do_access(0, 1'b1, 2'd1, 1'b0, 32'h6, 32'h00001234, rd, flt, lat);
    checks++; if (flt !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_half_resp: got fault=%b rdata=%h want 0/0", flt, rd); end
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h12340000) begin errors++; $display("FAIL store_half_readback: got %h want 12340000", rd); end
    do_access(0, 1'b1, 2'd0, 1'b0, 32'h4, 32'hFFFFFFAB, rd, flt, lat);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h123400AB) begin errors++; $display("FAIL store_byte0_readback: got %h want 123400AB", rd); end
    do_access(0, 1'b1, 2'd0, 1'b0, 32'h7, 32'h00000077, rd, flt, lat);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h773400AB) begin errors++; $display("FAIL store_byte3_readback: got %h want 773400AB", rd); end
  endtask

  task automatic test_fault();
    logic        t_wr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  t_sz [7] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [31:0] t_a  [7] = '{32'h2, 32'h0, 32'h1, 32'h100, 32'h5, 32'h100, 32'h4};
    logic [31:0] rd; logic flt; int lat;
    for (int i = 0; i < 7; i++) begin
      do_access(0, t_wr[i], t_sz[i], 1'b0, t_a[i], 32'hDEADBEEF, rd, flt, lat);
      checks++; if (flt !== 1'b1) begin errors++; $display("FAIL fault_flag[%0d]: got %b want 1", i, flt); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fault_rdata[%0d]: got %h want 0", i, rd); end
    end
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h773400AB) begin errors++; $display("FAIL fault_no_write_w1: got %h want 773400AB", rd); end
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL fault_no_write_w0: got %h want 8899AABB", rd); end
    do_setup(0, 32'hFC, 32'hA5A5A5A5);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, rd, flt, lat);
    checks++; if (flt !== 1'b0 || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL last_word: got fault=%b rdata=%h want 0/A5A5A5A5", flt, rd); end
  endtask

  task automatic test_setup_priority();
    logic [31:0] rd; logic flt; int lat;
    @(negedge clock);
    setup_valid[0] = 1'b1; setup_addr = 32'h8; setup_data = 32'hCAFEF00D;
    req_valid[0] = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8;
    resp_ready[0] = 1'b1;
    #1;
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL setup_blocks_req: got %b want 0", req_ready[0]); end
    @(negedge clock);
    setup_valid[0] = 1'b0;
    #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL req_after_setup_ready: got %b want 1", req_ready[0]); end
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    checks++; if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL setup_lands: got valid=%b rdata=%h want 1/CAFEF00D", resp_valid[0], resp_rdata[0]);
    end
    $display("txn u=0 setup+load addr=00000008 -> rdata=%h", resp_rdata[0]);
    @(posedge clock);
    do_setup(0, 32'h100, 32'hDEAD0000);
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL setup_oor_dropped: got %h want 8899AABB", rd); end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic flt; int lat;
    do_setup(1, 32'h10, 32'h11223344);
    @(negedge clock);
    req_valid[1] = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    resp_ready[1] = 1'b0;
    #1;
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL lat3_accept_ready: got %b want 1", req_ready[1]); end
    @(posedge clock);
    @(negedge clock);
    req_valid[1] = 1'b0;
    lat = 1;
    while (!resp_valid[1] && lat < 20) begin
      checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL lat3_wait_ready: got %b want 0", req_ready[1]); end
      @(negedge clock); lat++;
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL lat3_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid[1] !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, resp_valid[1]); end
      checks++; if (resp_rdata[1] !== 32'h11223344) begin errors++; $display("FAIL hold_rdata[%0d]: got %h want 11223344", i, resp_rdata[1]); end
      checks++; if (resp_fault[1] !== 1'b0) begin errors++; $display("FAIL hold_fault[%0d]: got %b want 0", i, resp_fault[1]); end
      checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready[1]); end
      setup_valid[1] = 1'b1; setup_addr = 32'h10; setup_data = 32'h0;
      @(negedge clock);
    end
    setup_valid[1] = 1'b0;
    resp_ready[1]  = 1'b1;
    $display("txn u=1 held load addr=00000010 -> rdata=%h lat=%0d", resp_rdata[1], lat);
    @(posedge clock);
    @(negedge clock);
    checks++; if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      errors++; $display("FAIL after_handshake: got valid=%b ready=%b want 0/1", resp_valid[1], req_ready[1]);
    end
    do_access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL setup_ignored_in_resp: got %h want 11223344", rd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL lat3_access_latency: got %0d want 3", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic flt; int lat;
    do_setup(1, 32'h14, 32'h01020304);
    @(negedge clock);
    req_valid[1] = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h55AA55AA; resp_ready[1] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid[1] = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got valid=%b ready=%b want 0/0", resp_valid[1], req_ready[1]);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if (resp_valid[1] !== 1'b0) begin errors++; $display("FAIL midreset_no_resp[%0d]: got %b want 0", i, resp_valid[1]); end
    end
    checks++; if (req_ready[1] !== 1'b1) begin errors++; $display("FAIL midreset_idle: got %b want 1", req_ready[1]); end
    $display("txn u=1 store abandoned by reset addr=00000014");
    do_access(1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL store_lost: got %h want 01020304", rd); end
    do_access(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, flt, lat);
    checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL mem_survives_reset: got %h want 8899AABB", rd); end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store();
    test_fault();
    test_setup_priority();
    test_latency();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
